cc_flag_generator: RTL and testbench
====================================

# cc_flag_generator

Multi-cycle integer execute unit that computes SPARC-style arithmetic/logic results and produces the integer condition codes (Z, N, C, V) together with the load-enable strobe consumed by the program status register. It is the write side of the condition-code path: the PSR samples its Z/N/C/V/LE inputs from this block, and the branch condition handler reads what the PSR has stored. Single-cycle ops and an iterative shift-add UMUL share one start/done handshake.

## Interface
- WIDTH, 32, operand/result width (≥ 2)
- Clk  in  1  rising-edge clock
- Clr  in  1  asynchronous active-high reset
- Start  in  1  request; sampled on Clk rising edge when Busy=0
- Op  in  4  op3[3:0]: 0000 ADD, 0001 AND, 0010 OR, 0011 XOR, 0100 SUB, 0101 ANDN, 0110 ORN, 0111 XNOR, 1000 ADDX, 1010 UMUL, 1100 SUBX; all others illegal
- SetCC  in  1  op updates condition codes (cc variant)
- A, B  in  WIDTH  operands
- Cin  in  1  carry in for ADDX/SUBX (PSR bit_C)
- Result  out  WIDTH  result (UMUL: low half)
- Y  out  WIDTH  UMUL high half; other ops leave it unchanged
- Z, N, C, V  out  1 each  condition codes, to PSR
- LE  out  1  one-cycle PSR load strobe
- Busy  out  1  op in progress
- Done  out  1  one-cycle completion pulse

## Operation
- All outputs reset to 0; state IDLE.
- FSM: IDLE, EXEC, MUL, DONE.
  - IDLE + Start: latch Op/SetCC/A/B/Cin. Go to MUL if Op=UMUL, else EXEC.
  - EXEC: next edge writes outputs, goes to DONE.
  - MUL: one shift-add iteration per edge, with a counter 0..WIDTH-1. After WIDTH iterations, the next edge writes outputs and goes to DONE.
  - DONE: Done=1 and Busy=0. Behaves like IDLE: Start is accepted here; otherwise go to IDLE.
- Arithmetic, computed at WIDTH+1 bits:
  - ADD/ADDX: R=A+B(+Cin). C=carry out. V=(A[msb]==B[msb]) && (R[msb]!=A[msb]).
  - SUB/SUBX: R=A−B(−Cin). C=borrow out. V=(A[msb]!=B[msb]) && (R[msb]!=A[msb]).
  - Logic (ANDN=A&~B, ORN=A|~B, XNOR=~(A^B)): C=0, V=0.
  - UMUL: {Y,Result}=A×B unsigned. C=0, V=0.
  - In all cases Z=(Result==0) and N=Result[msb].
- SetCC=1: Z/N/C/V updated on the write edge; LE=1 for the Done cycle.
- SetCC=0: Z/N/C/V hold their previous values; LE stays 0.
- Illegal Op: EXEC path. Result=0, Y unchanged, flags unchanged, LE=0, Done still pulses.
- Result, Y and flags hold until the next write edge.

## Timing
- Start sampled at edge k.
  - Non-UMUL: Busy=1 after edge k; write at edge k+1; Done/LE high for the cycle after edge k+1.
  - UMUL: iterations on edges k+1..k+WIDTH; write at edge k+WIDTH+1; Done/LE high for the cycle after that edge.
- Busy=1 in EXEC and MUL only. Start is ignored while Busy=1, and operand changes then have no effect.
- Start during the Done cycle is accepted at that edge (back-to-back issue). The PSR still sees LE for the completed op, because the PSR samples at the same edge.
- Clr asserted at any time, including mid-UMUL: all outputs 0 immediately, FSM to IDLE. The aborted op produces no Done or LE.
- A Start coincident with Clr deassertion is taken at the first edge with Clr=0.

## Test plan
- ADD, SetCC=1, A=0x7FFFFFFF, B=1 → Result=0x80000000, Z0 N1 C0 V1, LE=Done=1 for the one cycle after edge k+1.
- SUB, SetCC=1, A=5, B=5 → Result=0, Z1 N0 C0 V0. Then A=3, B=5 → Result=0xFFFFFFFE, Z0 N1 C1 V0.
- ADD, SetCC=0, A=0xFFFFFFFF, B=1 → Result=0, LE=0, flags keep the prior values. Follow with an illegal Op=1111 → Result=0, Done pulses, LE=0.
- ADDX, SetCC=1, Cin=1, A=0xFFFFFFFF, B=0 → Result=0, Z1 N0 C1 V0. Immediately issue back-to-back AND, SetCC=1, A=0xF0, B=0x0F during the Done cycle → Result=0, Z1, C0, V0, Done two edges later.
- UMUL, SetCC=1, A=0xFFFFFFFF, B=2 → Y=1, Result=0xFFFFFFFE, Z0 N1 C0 V0, Done after edge k+33. A Start pulsed at iteration 5 is ignored.
- UMUL started, Clr pulsed at iteration 10 → all outputs 0 immediately, no Done or LE. A subsequent ADD 2+3 with SetCC=1 → Result=5, all flags 0, normal timing.

Source files
------------

// File: rtl/cc_flag_generator.sv
// Multi-cycle SPARC-style integer execute unit: ALU ops, iterative UMUL and
// the Z/N/C/V condition codes plus the LE load strobe for the PSR.
module cc_flag_generator #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Start,
  input  logic [3:0]       Op,
  input  logic             SetCC,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Y,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V,
  output logic             LE,
  output logic             Busy,
  output logic             Done
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int MSB   = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL,
    DONE
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_AND  = 4'b0001,
    OP_OR   = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SUB  = 4'b0100,
    OP_ANDN = 4'b0101,
    OP_ORN  = 4'b0110,
    OP_XNOR = 4'b0111,
    OP_ADDX = 4'b1000,
    OP_UMUL = 4'b1010,
    OP_SUBX = 4'b1100
  } op_t;

  state_t state, state_next;

  // Operation captured at issue; the live inputs are ignored while busy.
  logic [3:0]         op_q;
  logic               setcc_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               cin_q;

  // Shift-add product: high half accumulates, low half starts as the multiplier.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     mul_sum;
  logic [CNT_W-1:0]   mul_cnt;
  logic               mul_fin;

  logic               le_pend;
  logic               accept;
  logic               write;

  logic               cin_eff;
  logic [WIDTH:0]     add_full;
  logic [WIDTH:0]     sub_full;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic               alu_legal;

  assign accept = Start && ((state == IDLE) || (state == DONE));
  assign write  = (state == EXEC) || ((state == MUL) && mul_fin);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Clr) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (Clr) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default first, so no path through the case leaves state_next
    // unassigned and infers a latch.
    state_next = state;
    unique case (state)
      IDLE, DONE: begin
        if (Start) state_next = (Op == OP_UMUL) ? MUL : EXEC;
        else       state_next = IDLE;
      end
      EXEC:    state_next = DONE;
      MUL:     if (mul_fin) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  assign Busy = (state == EXEC) || (state == MUL);
  assign Done = (state == DONE);
  assign LE   = (state == DONE) && le_pend;

  // ---------------------------------------------------------------------------
  // ALU, evaluated on the captured operands
  // ---------------------------------------------------------------------------
  assign cin_eff  = ((op_q == OP_ADDX) || (op_q == OP_SUBX)) && cin_q;
  assign add_full = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_eff};
  assign sub_full = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin_eff};
  assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_q} : '0);

  always_comb begin
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_legal = 1'b1;
    case (op_q)
      OP_ADD, OP_ADDX: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (a_q[MSB] == b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
      end
      OP_SUB, OP_SUBX: begin
        // Bit WIDTH of the zero-extended difference is the borrow out.
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (a_q[MSB] != b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_ANDN: alu_res = a_q & ~b_q;
      OP_ORN:  alu_res = a_q | ~b_q;
      OP_XNOR: alu_res = ~(a_q ^ b_q);
      OP_UMUL: alu_res = prod[WIDTH-1:0];
      default: alu_legal = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      op_q    <= '0;
      setcc_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      prod    <= '0;
      mul_cnt <= '0;
      mul_fin <= 1'b0;
      le_pend <= 1'b0;
      Result  <= '0;
      Y       <= '0;
      Z       <= 1'b0;
      N       <= 1'b0;
      C       <= 1'b0;
      V       <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= Op;
        setcc_q <= SetCC;
        a_q     <= A;
        b_q     <= B;
        cin_q   <= Cin;
        prod    <= {{WIDTH{1'b0}}, B};
        mul_cnt <= '0;
        mul_fin <= 1'b0;
      end

      if ((state == MUL) && !mul_fin) begin
        prod    <= {mul_sum, prod[WIDTH-1:1]};
        mul_cnt <= mul_cnt + 1'b1;
        if (mul_cnt == CNT_W'(WIDTH - 1)) mul_fin <= 1'b1;
      end

      if (write) begin
        Result  <= alu_res;
        le_pend <= setcc_q && alu_legal;
        if (op_q == OP_UMUL) Y <= prod[2*WIDTH-1:WIDTH];
        if (setcc_q && alu_legal) begin
          Z <= (alu_res == '0);
          N <= alu_res[MSB];
          C <= alu_c;
          V <= alu_v;
        end
      end
    end
  end

endmodule

// File: tb/tb_cc_flag_generator.sv
// Self-checking bench for cc_flag_generator: directed scenarios plus random
// ops compared against an arithmetic reference model.
module tb_cc_flag_generator;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Clr;
  logic         Start;
  logic [3:0]   Op;
  logic         SetCC;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic [W-1:0] Result;
  logic [W-1:0] Y;
  logic         Z, N, C, V, LE, Busy, Done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [W-1:0] m_res, m_y;
  logic         m_z, m_n, m_c, m_v, m_le;

  cc_flag_generator #(.WIDTH(W)) dut (
    .Clk(Clk), .Clr(Clr), .Start(Start), .Op(Op), .SetCC(SetCC),
    .A(A), .B(B), .Cin(Cin), .Result(Result), .Y(Y),
    .Z(Z), .N(N), .C(C), .V(V), .LE(LE), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_res = '0; m_y = '0;
    m_z = 0; m_n = 0; m_c = 0; m_v = 0; m_le = 0;
  endtask

  task automatic model_op(input logic [3:0] op, input logic s,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci);
    longint unsigned ua, ub, full;
    logic [W-1:0] r;
    logic c, v, legal;
    ua = a; ub = b;
    c = 0; v = 0; legal = 1; r = '0;
    case (op)
      4'b0000, 4'b1000: begin
        full = ua + ub + ((op == 4'b1000) ? longint'(ci) : 0);
        r = full[W-1:0];
        c = (full >> W) != 0;
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'b0100, 4'b1100: begin
        full = (op == 4'b1100) ? longint'(ci) : 0;
        r = a - b - full[W-1:0];
        c = ua < (ub + full);
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'b0001: r = a & b;
      4'b0010: r = a | b;
      4'b0011: r = a ^ b;
      4'b0101: r = a & ~b;
      4'b0110: r = a | ~b;
      4'b0111: r = ~(a ^ b);
      4'b1010: begin
        full = ua * ub;
        r = full[W-1:0];
        m_y = full[2*W-1:W];
      end
      default: legal = 0;
    endcase
    m_res = r;
    m_le  = s && legal;
    if (s && legal) begin
      m_z = (r == '0); m_n = r[W-1]; m_c = c; m_v = v;
    end
  endtask

  // Issues one op at the current point (just after a rising edge) and follows
  // it to its Done cycle. Returns with time inside the Done cycle.
  task automatic run_op(input string name, input logic [3:0] op, input logic s,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input int poke_at);
    int lat, edges;
    bit seen;
    lat = (op == 4'b1010) ? W + 1 : 1;
    model_op(op, s, a, b, ci);
    Start = 1; Op = op; SetCC = s; A = a; B = b; Cin = ci;
    @(posedge Clk); #1;
    Start = 0; Op = 4'($urandom); SetCC = 1'($urandom);
    A = $urandom; B = $urandom; Cin = 1'($urandom);
    n_checks++;
    if (Busy !== 1'b1 || Done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_after_issue: got Busy=%b Done=%b want Busy=1 Done=0", name, Busy, Done);
    end
    edges = 0; seen = 0;
    while (!seen && edges < 40) begin
      if (edges + 1 == poke_at) Start = 1;
      @(posedge Clk); #1;
      Start = 0;
      edges++;
      if (Done === 1'b1) seen = 1;
    end
    n_checks++;
    if (!seen || edges != lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges (done seen=%0b) want %0d", name, edges, seen, lat);
    end
    if (seen) begin
      n_checks++;
      if (Result !== m_res) begin
        n_fail++;
        $display("FAIL %s result: got %h want %h", name, Result, m_res);
      end
      n_checks++;
      if (Y !== m_y) begin
        n_fail++;
        $display("FAIL %s y: got %h want %h", name, Y, m_y);
      end
      n_checks++;
      if ({Z, N, C, V} !== {m_z, m_n, m_c, m_v}) begin
        n_fail++;
        $display("FAIL %s flags_znvc: got %b want %b", name, {Z, N, C, V}, {m_z, m_n, m_c, m_v});
      end
      n_checks++;
      if (LE !== m_le || Busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s le_busy: got LE=%b Busy=%b want LE=%b Busy=0", name, LE, Busy, m_le);
      end
    end
  endtask

  // One idle cycle after Done: strobes drop, outputs hold.
  task automatic idle_after(input string name);
    @(posedge Clk); #1;
    n_checks++;
    if (Done !== 1'b0 || LE !== 1'b0 || Busy !== 1'b0 || Result !== m_res ||
        {Z, N, C, V} !== {m_z, m_n, m_c, m_v}) begin
      n_fail++;
      $display("FAIL %s idle_hold: got Done=%b LE=%b Busy=%b R=%h ZNCV=%b want 0 0 0 R=%h ZNCV=%b",
               name, Done, LE, Busy, Result, {Z, N, C, V}, m_res, {m_z, m_n, m_c, m_v});
    end
  endtask

  task automatic check_const(input string name, input logic [W-1:0] r, input logic [3:0] f);
    n_checks++;
    if (Result !== r || {Z, N, C, V} !== f) begin
      n_fail++;
      $display("FAIL %s plan: got R=%h ZNCV=%b want R=%h ZNCV=%b", name, Result, {Z, N, C, V}, r, f);
    end
  endtask

  task automatic test_reset();
    Clr = 1; Start = 0; Op = '0; SetCC = 0; A = '0; B = '0; Cin = 0;
    model_reset();
    #3;
    n_checks++;
    if (Result !== '0 || Y !== '0 || {Z, N, C, V, LE, Busy, Done} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got R=%h Y=%h ZNCV=%b LE=%b Busy=%b Done=%b want all 0",
               Result, Y, {Z, N, C, V}, LE, Busy, Done);
    end
    @(posedge Clk); #1;
    Clr = 0;
  endtask

  task automatic test_add_overflow();
    run_op("add_ovf", 4'b0000, 1, 32'h7FFF_FFFF, 32'h1, 0, 0);
    check_const("add_ovf", 32'h8000_0000, 4'b0101);
    idle_after("add_ovf");
  endtask

  task automatic test_sub();
    run_op("sub_eq", 4'b0100, 1, 32'd5, 32'd5, 0, 0);
    check_const("sub_eq", 32'h0, 4'b1000);
    idle_after("sub_eq");
    run_op("sub_borrow", 4'b0100, 1, 32'd3, 32'd5, 0, 0);
    check_const("sub_borrow", 32'hFFFF_FFFE, 4'b0110);
    idle_after("sub_borrow");
  endtask

  task automatic test_nocc_illegal();
    run_op("add_nocc", 4'b0000, 0, 32'hFFFF_FFFF, 32'h1, 0, 0);
    check_const("add_nocc", 32'h0, 4'b0110);
    idle_after("add_nocc");
    run_op("illegal", 4'b1111, 1, 32'h1234_5678, 32'h9ABC_DEF0, 1, 0);
    check_const("illegal", 32'h0, 4'b0110);
    idle_after("illegal");
  endtask

  task automatic test_back_to_back();
    run_op("addx", 4'b1000, 1, 32'hFFFF_FFFF, 32'h0, 1, 0);
    check_const("addx", 32'h0, 4'b1010);
    run_op("b2b_and", 4'b0001, 1, 32'hF0, 32'h0F, 0, 0);
    check_const("b2b_and", 32'h0, 4'b1000);
    idle_after("b2b_and");
  endtask

  task automatic test_umul();
    run_op("umul", 4'b1010, 1, 32'hFFFF_FFFF, 32'h2, 0, 5);
    check_const("umul", 32'hFFFF_FFFE, 4'b0100);
    n_checks++;
    if (Y !== 32'h1) begin
      n_fail++;
      $display("FAIL umul_y_plan: got %h want 00000001", Y);
    end
    idle_after("umul");
  endtask

  task automatic test_clr_abort();
    bit strobe_seen;
    Start = 1; Op = 4'b1010; SetCC = 1; A = 32'h0001_2345; B = 32'h0000_6789; Cin = 0;
    @(posedge Clk); #1;
    Start = 0;
    repeat (10) @(posedge Clk);
    #1;
    Clr = 1;
    model_reset();
    #1;
    n_checks++;
    if (Result !== '0 || Y !== '0 || {Z, N, C, V, LE, Busy, Done} !== 7'b0) begin
      n_fail++;
      $display("FAIL clr_abort_outputs: got R=%h Y=%h ZNCV=%b LE=%b Busy=%b Done=%b want all 0",
               Result, Y, {Z, N, C, V}, LE, Busy, Done);
    end
    @(posedge Clk); #1;
    Clr = 0;
    strobe_seen = 0;
    repeat (40) begin
      @(posedge Clk); #1;
      if (Done !== 1'b0 || LE !== 1'b0 || Busy !== 1'b0) strobe_seen = 1;
    end
    n_checks++;
    if (strobe_seen) begin
      n_fail++;
      $display("FAIL clr_abort_no_done: got activity after abort want none");
    end
    // Start coincident with Clr deassertion.
    Clr = 1;
    @(posedge Clk); #1;
    Clr = 0;
    run_op("add_after_clr", 4'b0000, 1, 32'd2, 32'd3, 0, 0);
    check_const("add_after_clr", 32'd5, 4'b0000);
    idle_after("add_after_clr");
  endtask

  task automatic test_random();
    logic [3:0] ops [14] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                             4'd8, 4'd10, 4'd12, 4'd9, 4'd13, 4'd15};
    logic [W-1:0] corners [5] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1};
    logic [W-1:0] a, b;
    logic [3:0] op;
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 13)];
      a = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
      b = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
      run_op("random", op, 1'($urandom), a, b, 1'($urandom), 0);
      if ($urandom_range(0, 1) == 0) idle_after("random");
    end
    idle_after("random_end");
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub();
    test_nocc_illegal();
    test_back_to_back();
    test_umul();
    test_clr_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
